// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_bus_arbiter
// Purpose  : Round-robin arbiter and master for the shared register bus.
//            Grants one requester at a time, runs a single select/ack
//            handshake with the per-port register decoders, and returns
//            read data or an error (timeout / bad address) to the winner.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bus_arbiter #(
  parameter int NUM_OF_PORTS = 4,
  parameter int W_WIDTH      = 8,
  parameter int NUM_REQ      = 2,
  parameter int TIMEOUT      = 15,
  localparam int AW          = (NUM_OF_PORTS > 1) ? $clog2(NUM_OF_PORTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // requester side
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_wr,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*W_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [W_WIDTH-1:0]       rsp_rdata,
  output logic                     rsp_err,
  // register bus side
  output logic                     sel_en,
  output logic                     wr_rd_s,
  output logic [AW-1:0]            addr,
  output logic [W_WIDTH-1:0]       wdata,
  input  logic                     bus_ack,
  input  logic [W_WIDTH-1:0]       bus_rd_data
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic                 sel_en_q, sel_en_d;
  logic                 wr_rd_s_q, wr_rd_s_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [W_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [W_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;

  // round-robin search results
  int                   cand;
  logic [GW-1:0]        cand_idx;
  logic                 win_found;
  logic [GW-1:0]        win_idx;
  logic [AW-1:0]        win_addr;
  logic                 win_bad;

  // Pick the first valid requester after the last one granted, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = GW'(cand);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Winner's address; only reachable as "bad" when NUM_OF_PORTS is not 2^n.
  always_comb begin
    win_addr = req_addr[win_idx*AW +: AW];
    win_bad  = (int'(win_addr) >= NUM_OF_PORTS);
  end

  // Next-state, bus and response computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    sel_en_d     = sel_en_q;
    wr_rd_s_d    = wr_rd_s_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    req_ready    = '0;

    case (state_q)
      IDLE: begin
        // A lingering ack from the previous access blocks a new grant.
        if (win_found && !bus_ack) begin
          req_ready[win_idx] = 1'b1;
          last_grant_d       = win_idx;
          if (win_bad) begin
            state_d              = RESP;
            rsp_valid_d[win_idx] = 1'b1;
            rsp_rdata_d          = '0;
            rsp_err_d            = 1'b1;
          end else begin
            state_d   = ACCESS;
            sel_en_d  = 1'b1;
            wr_rd_s_d = req_wr[win_idx];
            addr_d    = win_addr;
            wdata_d   = req_wdata[win_idx*W_WIDTH +: W_WIDTH];
          end
        end
      end

      ACCESS: begin
        if (bus_ack || (cnt_q == CW'(TIMEOUT - 1))) begin
          state_d                   = RESP;
          cnt_d                     = '0;
          sel_en_d                  = 1'b0;
          wr_rd_s_d                 = 1'b0;
          addr_d                    = '0;
          wdata_d                   = '0;
          rsp_valid_d[last_grant_q] = 1'b1;
          if (bus_ack) begin
            rsp_rdata_d = wr_rd_s_q ? '0 : bus_rd_data;
            rsp_err_d   = 1'b0;
          end else begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, bus and response registers; reset forces the bus idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      sel_en_q     <= 1'b0;
      wr_rd_s_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      sel_en_q     <= sel_en_d;
      wr_rd_s_q    <= wr_rd_s_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign sel_en    = sel_en_q;
  assign wr_rd_s   = wr_rd_s_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bus_arbiter
// Purpose  : Directed self-checking bench for reg_bus_arbiter, with a simple
//            registered-ack decoder model on the bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // main instance (4 ports)
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_wr = '0;
  logic [3:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err, sel_en, wr_rd_s;
  logic [1:0]  addr;
  logic [7:0]  wdata;
  logic        bus_ack;
  logic [7:0]  bus_rd_data;

  // second instance with 3 ports, for the bad-address case
  logic [1:0]  b_req_valid = '0;
  logic [1:0]  b_req_wr = '0;
  logic [3:0]  b_req_addr = '0;
  logic [15:0] b_req_wdata = '0;
  logic [1:0]  b_req_ready, b_rsp_valid;
  logic [7:0]  b_rsp_rdata;
  logic        b_rsp_err, b_sel_en, b_wr_rd_s;
  logic [1:0]  b_addr;
  logic [7:0]  b_wdata;
  wire         b_bus_ack = 1'b0;
  wire [7:0]   b_bus_rd_data = 8'h00;

  logic        ack_en = 1'b1;
  logic [7:0]  mem [0:3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_bus_arbiter #(.NUM_OF_PORTS(4), .W_WIDTH(8), .NUM_REQ(2), .TIMEOUT(15)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sel_en(sel_en), .wr_rd_s(wr_rd_s), .addr(addr), .wdata(wdata),
    .bus_ack(bus_ack), .bus_rd_data(bus_rd_data)
  );

  reg_bus_arbiter #(.NUM_OF_PORTS(3), .W_WIDTH(8), .NUM_REQ(2), .TIMEOUT(15)) u_bad (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_wr(b_req_wr), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .sel_en(b_sel_en), .wr_rd_s(b_wr_rd_s), .addr(b_addr), .wdata(b_wdata),
    .bus_ack(b_bus_ack), .bus_rd_data(b_bus_rd_data)
  );

  // Decoder model: ack and read data one cycle after sel_en is seen.
  always @(posedge clk) begin
    if (!rst_n) begin
      bus_ack     <= 1'b0;
      bus_rd_data <= 8'h00;
      mem[0]      <= 8'h11;
      mem[1]      <= 8'h5A;
      mem[2]      <= 8'hA5;
      mem[3]      <= 8'h77;
    end else begin
      bus_ack     <= sel_en & ack_en;
      bus_rd_data <= (sel_en & ack_en) ? mem[addr] : 8'h00;
      if (sel_en & wr_rd_s & ack_en) mem[addr] <= wdata;
    end
  end

  // Issue one request on the main instance and observe it until its response.
  task automatic run_req(input int r, input logic wr, input logic [1:0] a, input logic [7:0] d,
                         output int g_cyc, output int s_first, output int s_cnt, output int r_cyc,
                         output logic [1:0] o_addr, output logic o_wr, output logic [7:0] o_wdata,
                         output logic [1:0] rv, output logic [7:0] rd, output logic er);
    g_cyc = -1; s_first = -1; s_cnt = 0; r_cyc = -1;
    o_addr = '0; o_wr = 1'b0; o_wdata = '0; rv = '0; rd = '0; er = 1'b0;
    @(posedge clk); #1;
    req_valid[r] = 1'b1;
    req_wr[r] = wr;
    req_addr[r*2 +: 2] = a;
    req_wdata[r*8 +: 8] = d;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (g_cyc < 0 && req_ready[r]) g_cyc = c;
      if (sel_en) begin
        s_cnt++;
        if (s_first < 0) begin
          s_first = c; o_addr = addr; o_wr = wr_rd_s; o_wdata = wdata;
        end
      end
      if (rsp_valid != 2'b00) begin
        r_cyc = c; rv = rsp_valid; rd = rsp_rdata; er = rsp_err;
        break;
      end
      @(posedge clk); #1;
      if (g_cyc >= 0) req_valid[r] = 1'b0;
    end
    req_valid[r] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sel_en, wr_rd_s, addr, wdata, rsp_valid, rsp_rdata, rsp_err} !== 23'd0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {sel_en, wr_rd_s, addr, wdata, rsp_valid, rsp_rdata, rsp_err});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({sel_en, rsp_valid, req_ready, b_sel_en, b_rsp_valid} !== 8'd0) begin
      errors++; $display("FAIL reset_idle got %h exp 0", {sel_en, rsp_valid, req_ready, b_sel_en, b_rsp_valid});
    end
  endtask

  task automatic test_single_read();
    int g, sf, sc, rc; logic [1:0] ba; logic bw; logic [7:0] bd; logic [1:0] rv; logic [7:0] rd; logic er;
    run_req(0, 1'b0, 2'd2, 8'h00, g, sf, sc, rc, ba, bw, bd, rv, rd, er);
    checks++; if (g !== 0)        begin errors++; $display("FAIL rd_grant_cyc got %0d exp 0", g); end
    checks++; if (sf !== 1)       begin errors++; $display("FAIL rd_sel_first got %0d exp 1", sf); end
    checks++; if (sc !== 2)       begin errors++; $display("FAIL rd_sel_cycles got %0d exp 2", sc); end
    checks++; if (ba !== 2'd2)    begin errors++; $display("FAIL rd_bus_addr got %0d exp 2", ba); end
    checks++; if (bw !== 1'b0)    begin errors++; $display("FAIL rd_wr_rd_s got %0b exp 0", bw); end
    checks++; if (rc !== 3)       begin errors++; $display("FAIL rd_rsp_cyc got %0d exp 3", rc); end
    checks++; if (rv !== 2'b01)   begin errors++; $display("FAIL rd_rsp_valid got %b exp 01", rv); end
    checks++; if (rd !== 8'hA5)   begin errors++; $display("FAIL rd_rdata got %h exp a5", rd); end
    checks++; if (er !== 1'b0)    begin errors++; $display("FAIL rd_err got %0b exp 0", er); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00 || rsp_rdata !== 8'hA5) begin
      errors++; $display("FAIL rd_pulse_hold got valid=%b rdata=%h exp 00/a5", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_single_write();
    int g, sf, sc, rc; logic [1:0] ba; logic bw; logic [7:0] bd; logic [1:0] rv; logic [7:0] rd; logic er;
    run_req(1, 1'b1, 2'd3, 8'h3C, g, sf, sc, rc, ba, bw, bd, rv, rd, er);
    checks++; if (g !== 0)        begin errors++; $display("FAIL wr_grant_cyc got %0d exp 0", g); end
    checks++; if (sf !== 1 || sc !== 2) begin errors++; $display("FAIL wr_sel got first=%0d cnt=%0d exp 1/2", sf, sc); end
    checks++; if (bw !== 1'b1)    begin errors++; $display("FAIL wr_wr_rd_s got %0b exp 1", bw); end
    checks++; if (ba !== 2'd3)    begin errors++; $display("FAIL wr_bus_addr got %0d exp 3", ba); end
    checks++; if (bd !== 8'h3C)   begin errors++; $display("FAIL wr_wdata got %h exp 3c", bd); end
    checks++; if (rc !== 3)       begin errors++; $display("FAIL wr_rsp_cyc got %0d exp 3", rc); end
    checks++; if (rv !== 2'b10)   begin errors++; $display("FAIL wr_rsp_valid got %b exp 10", rv); end
    checks++; if (rd !== 8'h00)   begin errors++; $display("FAIL wr_rdata got %h exp 00", rd); end
    checks++; if (er !== 1'b0)    begin errors++; $display("FAIL wr_err got %0b exp 0", er); end
  endtask

  task automatic test_contention();
    int n; int cnt0; int cnt1; int who; int g_cyc[6]; logic [1:0] g_rdy[6];
    n = 0; cnt0 = 0; cnt1 = 0;
    @(posedge clk); #1;
    req_wr = 2'b00;
    req_addr = {2'd1, 2'd2};
    req_valid = 2'b11;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk);
      who = -1;
      if (req_ready != 2'b00) begin
        g_cyc[n] = c; g_rdy[n] = req_ready; n++;
        who = req_ready[1] ? 1 : 0;
      end
      @(posedge clk); #1;
      if (who == 0) begin cnt0++; if (cnt0 == 3) req_valid[0] = 1'b0; end
      if (who == 1) begin cnt1++; if (cnt1 == 3) req_valid[1] = 1'b0; end
    end
    req_valid = 2'b00;
    checks++; if (n !== 6) begin errors++; $display("FAIL cont_grant_count got %0d exp 6", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (g_rdy[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL cont_order[%0d] got %b exp %b", i, g_rdy[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      if (i > 0) begin
        checks++;
        if (g_cyc[i] - g_cyc[i-1] !== 4) begin
          errors++; $display("FAIL cont_spacing[%0d] got %0d exp 4", i, g_cyc[i] - g_cyc[i-1]);
        end
      end
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic test_timeout();
    int g, sf, sc, rc; logic [1:0] ba; logic bw; logic [7:0] bd; logic [1:0] rv; logic [7:0] rd; logic er;
    ack_en = 1'b0;
    run_req(0, 1'b0, 2'd1, 8'h00, g, sf, sc, rc, ba, bw, bd, rv, rd, er);
    checks++; if (sf !== 1)       begin errors++; $display("FAIL to_sel_first got %0d exp 1", sf); end
    checks++; if (sc !== 15)      begin errors++; $display("FAIL to_sel_cycles got %0d exp 15", sc); end
    checks++; if (rc !== 16)      begin errors++; $display("FAIL to_rsp_cyc got %0d exp 16", rc); end
    checks++; if (rv !== 2'b01)   begin errors++; $display("FAIL to_rsp_valid got %b exp 01", rv); end
    checks++; if (er !== 1'b1)    begin errors++; $display("FAIL to_err got %0b exp 1", er); end
    checks++; if (rd !== 8'h00)   begin errors++; $display("FAIL to_rdata got %h exp 00", rd); end
    ack_en = 1'b1;
    @(posedge clk);
    run_req(0, 1'b0, 2'd2, 8'h00, g, sf, sc, rc, ba, bw, bd, rv, rd, er);
    checks++; if (rc !== 3)       begin errors++; $display("FAIL to_next_rsp_cyc got %0d exp 3", rc); end
    checks++;
    if (er !== 1'b0 || rd !== 8'hA5) begin
      errors++; $display("FAIL to_next_rsp got err=%0b rdata=%h exp 0/a5", er, rd);
    end
  endtask

  task automatic test_reset_access();
    logic seen;
    @(posedge clk); #1;
    req_wr = 2'b00; req_addr = {2'd1, 2'd2}; req_valid = 2'b01;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_pre_grant got %b exp 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    checks++; if (sel_en !== 1'b1) begin errors++; $display("FAIL rst_sel_before got %0b exp 1", sel_en); end
    rst_n = 1'b0;
    #1;
    checks++; if (sel_en !== 1'b0) begin errors++; $display("FAIL rst_sel_async got %0b exp 0", sel_en); end
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) seen = 1'b1;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    if (rsp_valid !== 2'b00) seen = 1'b1;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_rsp got %0b exp 0", seen); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_first_grant got %b exp 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (6) @(posedge clk);
  endtask

  task automatic test_bad_addr();
    logic sel_seen;
    sel_seen = 1'b0;
    @(posedge clk); #1;
    b_req_wr = 2'b00; b_req_addr = {2'd0, 2'd3}; b_req_valid = 2'b01;
    @(negedge clk);
    if (b_sel_en !== 1'b0) sel_seen = 1'b1;
    checks++; if (b_req_ready !== 2'b01) begin errors++; $display("FAIL bad_grant got %b exp 01", b_req_ready); end
    @(posedge clk); #1;
    b_req_valid = 2'b00;
    @(negedge clk);
    if (b_sel_en !== 1'b0) sel_seen = 1'b1;
    checks++; if (b_rsp_valid !== 2'b01) begin errors++; $display("FAIL bad_rsp_valid got %b exp 01", b_rsp_valid); end
    checks++;
    if (b_rsp_err !== 1'b1 || b_rsp_rdata !== 8'h00) begin
      errors++; $display("FAIL bad_rsp got err=%0b rdata=%h exp 1/00", b_rsp_err, b_rsp_rdata);
    end
    repeat (3) begin
      @(negedge clk);
      if (b_sel_en !== 1'b0) sel_seen = 1'b1;
    end
    checks++; if (sel_seen !== 1'b0) begin errors++; $display("FAIL bad_sel_en got %0b exp 0", sel_seen); end
    checks++; if (b_rsp_valid !== 2'b00) begin errors++; $display("FAIL bad_pulse got %b exp 00", b_rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_timeout();
    test_reset_access();
    test_bad_addr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
